// File: rtl/fpu_fmul_pipe.sv
// fpu_fmul_pipe
//   Elastic IEEE-754 multiply pipeline (x*y) for a format chosen by EXP_W/MAN_W.
//   Subnormal inputs read as signed zero and tiny results flush to signed zero.
//   Stage 1 holds the raw product and classification.
//   Stage 2 normalises, rounds and packs the result.
//   Stages 3..STAGES only hold the result.
//   Every stage has its own valid bit, so bubbles collapse.
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_in_valid/o_in_ready   operation handshake (o_in_ready drops during i_flush)
//   i_x, i_y                packed operands
//   i_rm                    rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE
//   i_tag                   opaque tag, returned on o_out_tag
//   i_flush                 kills every in-flight operation on this edge
//   o_out_valid/i_out_ready result handshake
//   o_result, o_flags       packed product, {NV, DZ, OF, UF, NX}
//   o_out_tag               tag of the result
module fpu_fmul_pipe #(
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23,
   parameter int TAG_W  = 5,
   parameter int STAGES = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [EXP_W+MAN_W:0]   i_x,
   input  logic [EXP_W+MAN_W:0]   i_y,
   input  logic [2:0]             i_rm,
   input  logic [TAG_W-1:0]       i_tag,
   input  logic                   i_flush,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [EXP_W+MAN_W:0]   o_result,
   output logic [4:0]             o_flags,
   output logic [TAG_W-1:0]       o_out_tag
);

   localparam int W  = EXP_W + MAN_W + 1;
   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_OVF = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
   localparam logic [W-2:0] MAXF = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

   // ---------------- handshake ----------------
   logic [STAGES:1] r_vld;
   logic [STAGES:1] w_rdy;

   // ready_i = !v_i | ready_(i+1), unrolled from the output end
   always_comb begin
      logic w_acc;
      w_rdy = '0;
      w_acc = i_out_ready;
      for (int k = STAGES; k >= 1; k--) begin
         w_acc    = w_acc | ~r_vld[k];
         w_rdy[k] = w_acc;
      end
   end

   assign o_in_ready = w_rdy[1] & ~i_flush;

   // ---------------- stage 1: classify, multiply ----------------
   logic                 w_xs, w_ys, w_sign;
   logic [EXP_W-1:0]     w_xe, w_ye;
   logic [MAN_W-1:0]     w_xm, w_ym;
   logic                 w_x_zero, w_y_zero, w_x_inf, w_y_inf;
   logic                 w_x_nan, w_y_nan, w_x_snan, w_y_snan, w_inv;
   logic [PW-1:0]        w_prod;
   logic signed [EW-1:0] w_exp;
   logic                 w_spec;
   logic [W-1:0]         w_spec_res;
   logic [4:0]           w_spec_flg;

   assign {w_xs, w_xe, w_xm} = i_x;
   assign {w_ys, w_ye, w_ym} = i_y;
   assign w_sign   = w_xs ^ w_ys;
   // exp==0 covers both true zero and subnormals (DAZ)
   assign w_x_zero = (w_xe == '0);
   assign w_y_zero = (w_ye == '0);
   assign w_x_inf  = (&w_xe) & (w_xm == '0);
   assign w_y_inf  = (&w_ye) & (w_ym == '0);
   assign w_x_nan  = (&w_xe) & (|w_xm);
   assign w_y_nan  = (&w_ye) & (|w_ym);
   assign w_x_snan = w_x_nan & ~w_xm[MAN_W-1];
   assign w_y_snan = w_y_nan & ~w_ym[MAN_W-1];
   assign w_inv    = (w_x_inf & w_y_zero) | (w_y_inf & w_x_zero);
   assign w_prod   = PW'({1'b1, w_xm}) * PW'({1'b1, w_ym});
   assign w_exp    = EW'(w_xe) + EW'(w_ye) - BIAS;

   always_comb begin
      w_spec     = 1'b1;
      w_spec_res = '0;
      w_spec_flg = '0;
      if (w_x_nan | w_y_nan | w_inv) begin
         w_spec_res = QNAN;
         w_spec_flg = {w_x_snan | w_y_snan | w_inv, 4'b0000};
      end else if (w_x_inf | w_y_inf) begin
         w_spec_res = {w_sign, INF};
      end else if (w_x_zero | w_y_zero) begin
         w_spec_res = {w_sign, {(W-1){1'b0}}};
      end else begin
         w_spec = 1'b0;
      end
   end

   logic                 r_s1_spec, r_s1_sign;
   logic [W-1:0]         r_s1_sres;
   logic [4:0]           r_s1_sflg;
   logic signed [EW-1:0] r_s1_exp;
   logic [PW-1:0]        r_s1_prod;
   logic [2:0]           r_s1_rm;
   logic [TAG_W-1:0]     r_s1_tag;

   // ---------------- stage 2: normalise, round, pack ----------------
   logic                 w_hi, w_g, w_st, w_nx, w_inc, w_of, w_uf;
   logic [MAN_W-1:0]     w_man;
   logic [MAN_W:0]       w_mr;
   logic signed [EW-1:0] w_exp_n, w_exp_r;
   logic [W-1:0]         w_s2_res;
   logic [4:0]           w_s2_flg;

   // product of two [1,2) significands lies in [1,4); top bit selects the shift
   assign w_hi    = r_s1_prod[PW-1];
   assign w_man   = w_hi ? r_s1_prod[PW-2:MAN_W+1] : r_s1_prod[PW-3:MAN_W];
   assign w_g     = w_hi ? r_s1_prod[MAN_W]        : r_s1_prod[MAN_W-1];
   assign w_st    = w_hi ? |r_s1_prod[MAN_W-1:0]   : |r_s1_prod[MAN_W-2:0];
   assign w_nx    = w_g | w_st;
   assign w_exp_n = r_s1_exp + EW'(w_hi);

   always_comb begin
      w_inc = 1'b0;
      case (r_s1_rm)
         3'b001:  w_inc = 1'b0;
         3'b010:  w_inc = r_s1_sign & w_nx;
         3'b011:  w_inc = ~r_s1_sign & w_nx;
         3'b100:  w_inc = w_g;
         default: w_inc = w_g & (w_st | w_man[0]);
      endcase
   end

   // carry out of the mantissa leaves the stored field at zero (1.000 * 2)
   assign w_mr    = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
   assign w_exp_r = w_exp_n + EW'(w_mr[MAN_W]);
   assign w_of    = ~w_exp_r[EW-1] & (w_exp_r >= EXP_OVF);
   assign w_uf    = w_exp_r[EW-1] | (w_exp_r == '0);

   always_comb begin
      w_s2_res = {r_s1_sign, w_exp_r[EXP_W-1:0], w_mr[MAN_W-1:0]};
      w_s2_flg = {4'b0000, w_nx};
      if (r_s1_spec) begin
         w_s2_res = r_s1_sres;
         w_s2_flg = r_s1_sflg;
      end else if (w_of) begin
         w_s2_flg = 5'b00101;
         case (r_s1_rm)
            3'b001:  w_s2_res = {r_s1_sign, MAXF};
            3'b010:  w_s2_res = r_s1_sign ? {1'b1, INF}  : {1'b0, MAXF};
            3'b011:  w_s2_res = r_s1_sign ? {1'b1, MAXF} : {1'b0, INF};
            default: w_s2_res = {r_s1_sign, INF};
         endcase
      end else if (w_uf) begin
         w_s2_res = {r_s1_sign, {(W-1){1'b0}}};
         w_s2_flg = 5'b00011;
      end
   end

   // ---------------- registers ----------------
   logic [W-1:0]     r_res [STAGES:2];
   logic [4:0]       r_flg [STAGES:2];
   logic [TAG_W-1:0] r_tag [STAGES:2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld     <= '0;
         r_s1_spec <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_sres <= '0;
         r_s1_sflg <= '0;
         r_s1_exp  <= '0;
         r_s1_prod <= '0;
         r_s1_rm   <= '0;
         r_s1_tag  <= '0;
         for (int k = 2; k <= STAGES; k++) begin
            r_res[k] <= '0;
            r_flg[k] <= '0;
            r_tag[k] <= '0;
         end
      end else if (i_flush) begin
         r_vld <= '0;
      end else begin
         // holding stages: pass through when downstream frees up
         for (int k = STAGES; k >= 3; k--) begin
            if (w_rdy[k]) begin
               r_vld[k] <= r_vld[k-1];
               if (r_vld[k-1]) begin
                  r_res[k] <= r_res[k-1];
                  r_flg[k] <= r_flg[k-1];
                  r_tag[k] <= r_tag[k-1];
               end
            end
         end
         if (w_rdy[2]) begin
            r_vld[2] <= r_vld[1];
            if (r_vld[1]) begin
               r_res[2] <= w_s2_res;
               r_flg[2] <= w_s2_flg;
               r_tag[2] <= r_s1_tag;
            end
         end
         if (w_rdy[1]) begin
            r_vld[1] <= i_in_valid;
            if (i_in_valid) begin
               r_s1_spec <= w_spec;
               r_s1_sign <= w_sign;
               r_s1_sres <= w_spec_res;
               r_s1_sflg <= w_spec_flg;
               r_s1_exp  <= w_exp;
               r_s1_prod <= w_prod;
               r_s1_rm   <= i_rm;
               r_s1_tag  <= i_tag;
            end
         end
      end
   end

   assign o_out_valid = r_vld[STAGES];
   assign o_result    = r_res[STAGES];
   assign o_flags     = r_flg[STAGES];
   assign o_out_tag   = r_tag[STAGES];

endmodule

// File: tb/tb_fpu_fmul_pipe.sv
// Bench for fpu_fmul_pipe (binary32, STAGES=3): directed vector table, backpressure,
// flush and reset sequences, then randomized traffic against an integer-arithmetic model.
module tb_fpu_fmul_pipe;
   logic        clk = 1'b0;
   logic        i_rst_n, i_in_valid, o_in_ready, i_flush, o_out_valid, i_out_ready;
   logic [31:0] i_x, i_y, o_result;
   logic [2:0]  i_rm;
   logic [4:0]  i_tag, o_flags, o_out_tag;

   always #5 clk = ~clk;

   fpu_fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5), .STAGES(3)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_x(i_x), .i_y(i_y), .i_rm(i_rm), .i_tag(i_tag), .i_flush(i_flush),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_result(o_result),
      .o_flags(o_flags), .o_out_tag(o_out_tag)
   );

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // Reference: exact integer product, then rounding from quotient/remainder.
   function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                                 output logic [31:0] res, output logic [4:0] flg);
      int ex, ey, e, sh;
      longint unsigned mx, my, sig, q, r, half;
      bit s, xnan, ynan, xsn, ysn, xinf, yinf, xz, yz, inv, up, inx;
      ex = int'(x[30:23]);  ey = int'(y[30:23]);
      mx = 64'(x[22:0]);    my = 64'(y[22:0]);
      s  = x[31] ^ y[31];
      xnan = (ex == 255) && (mx != 0);  ynan = (ey == 255) && (my != 0);
      xsn  = xnan && (mx < (64'd1 << 22)); ysn = ynan && (my < (64'd1 << 22));
      xinf = (ex == 255) && (mx == 0);  yinf = (ey == 255) && (my == 0);
      xz   = (ex == 0);                 yz   = (ey == 0);
      inv  = (xinf && yz) || (yinf && xz);
      res = 32'h0; flg = 5'b0;
      if (xnan || ynan || inv) begin
         res = 32'h7FC00000;
         flg = (xsn || ysn || inv) ? 5'b10000 : 5'b00000;
      end else if (xinf || yinf) begin
         res = {s, 8'hFF, 23'h0};
      end else if (xz || yz) begin
         res = {s, 31'h0};
      end else begin
         sig  = ((64'd1 << 23) + mx) * ((64'd1 << 23) + my);
         e    = ex + ey - 127;
         sh   = (sig >= (64'd1 << 47)) ? 24 : 23;
         e    = e + sh - 23;
         q    = sig >> sh;
         r    = sig - (q << sh);
         half = 64'd1 << (sh - 1);
         inx  = (r != 0);
         case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = s && inx;
            3'd3:    up = !s && inx;
            3'd4:    up = (r >= half);
            default: up = (r > half) || ((r == half) && (q % 2 == 1));
         endcase
         q = q + (up ? 64'd1 : 64'd0);
         if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e++; end
         if (e >= 255) begin
            flg = 5'b00101;
            case (rm)
               3'd1:    res = {s, 31'h7F7FFFFF};
               3'd2:    res = s ? 32'hFF800000 : 32'h7F7FFFFF;
               3'd3:    res = s ? 32'hFF7FFFFF : 32'h7F800000;
               default: res = {s, 31'h7F800000};
            endcase
         end else if (e <= 0) begin
            res = {s, 31'h0};
            flg = 5'b00011;
         end else begin
            res = {s, 8'(e), 23'(q - (64'd1 << 23))};
            flg = {4'b0, inx};
         end
      end
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int k;
      v = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) begin
         case ($urandom_range(0, 5))
            0: v = {v[31], 31'h0};
            1: v = {v[31], 31'h7F800000};
            2: v = 32'h7FC00000;
            3: v = 32'h7F800001;
            4: v[30:23] = 8'h00;
            default: v = {v[31], 31'h7F7FFFFF};
         endcase
      end else if (k < 7) begin
         v[30:23] = 8'($urandom_range(90, 165));
      end
      return v;
   endfunction

   // Single operation with out_ready held high; lat counts edges from accept to out_valid.
   task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                          input logic [4:0] tag, output logic [31:0] res, output logic [4:0] flg,
                          output logic [4:0] otag, output int lat);
      int w;
      res = '0; flg = '0; otag = '0; lat = -1; w = 0;
      @(negedge clk);
      i_x = x; i_y = y; i_rm = rm; i_tag = tag; i_in_valid = 1'b1; i_out_ready = 1'b1;
      #1;
      while (!o_in_ready && w < 20) begin @(negedge clk); #1; w++; end
      @(posedge clk);
      #1 i_in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (o_out_valid) begin
            res = o_result; flg = o_flags; otag = o_out_tag; lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [31:0] x, y;
      logic [2:0]  rm;
      logic [31:0] res;
      logic [4:0]  flg;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg, tag;
   } exp_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      exp_t sb[$];
      exp_t e;
      logic [31:0] res, bx[5], by[5], bres[5];
      logic [4:0]  flg, otag, bflg[5];
      int lat, acc, got, stale, sent;

      vecs.push_back('{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000});
      vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001});
      vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001});
      vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'b00001});
      vecs.push_back('{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000});
      vecs.push_back('{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000});
      vecs.push_back('{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00000});
      vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101});
      vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101});
      vecs.push_back('{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011});
      vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd2, 32'h7F7FFFFF, 5'b00101});
      vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b00101});
      vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101});
      vecs.push_back('{32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000});
      vecs.push_back('{32'h80000001, 32'h3F800000, 3'd0, 32'h80000000, 5'b00000});
      vecs.push_back('{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 5'b00001});
      vecs.push_back('{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 5'b00001});
      vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd6, 32'h3F800002, 5'b00001});
      vecs.push_back('{32'h00800000, 32'h00800000, 3'd3, 32'h00000000, 5'b00011});

      i_rst_n = 1'b0; i_in_valid = 1'b0; i_flush = 1'b0; i_out_ready = 1'b0;
      i_x = '0; i_y = '0; i_rm = '0; i_tag = '0;

      // reset state
      #12;
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);
      chk("rst_result", o_result, 32'h0);
      chk("rst_flags", 32'(o_flags), 32'h0);
      chk("rst_out_tag", 32'(o_out_tag), 32'h0);
      @(negedge clk); i_rst_n = 1'b1; #1;
      chk("rst_in_ready", 32'(o_in_ready), 32'd1);

      // directed vectors
      foreach (vecs[i]) begin
         run_one(vecs[i].x, vecs[i].y, vecs[i].rm, 5'(i + 1), res, flg, otag, lat);
         chk($sformatf("vec%0d_latency", i), lat, 32'd2);
         chk($sformatf("vec%0d_result", i), res, vecs[i].res);
         chk($sformatf("vec%0d_flags", i), 32'(flg), 32'(vecs[i].flg));
         chk($sformatf("vec%0d_tag", i), 32'(otag), 32'(i + 1));
      end

      // backpressure: 5 offered with out_ready low, only 3 fit
      for (int k = 0; k < 5; k++) begin
         bx[k] = {1'b0, 8'd127, 23'($urandom)};
         by[k] = {1'b0, 8'd128, 23'($urandom)};
         model(bx[k], by[k], 3'd0, bres[k], bflg[k]);
      end
      @(negedge clk);
      i_out_ready = 1'b0; i_rm = 3'd0; acc = 0;
      for (int c = 0; c < 8; c++) begin
         i_in_valid = (acc < 5);
         if (acc < 5) begin i_x = bx[acc]; i_y = by[acc]; i_tag = 5'(20 + acc); end
         #1;
         if (i_in_valid && o_in_ready) acc++;
         @(negedge clk);
      end
      chk("bp_accepted", acc, 32'd3);
      #1 chk("bp_in_ready_low", 32'(o_in_ready), 32'd0);
      i_out_ready = 1'b1; got = 0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         i_in_valid = (acc < 5);
         if (acc < 5) begin i_x = bx[acc]; i_y = by[acc]; i_tag = 5'(20 + acc); end
         #1;
         if (o_out_valid) begin
            chk($sformatf("bp_tag%0d", got), 32'(o_out_tag), 32'(20 + got));
            chk($sformatf("bp_res%0d", got), o_result, bres[got]);
            chk($sformatf("bp_flg%0d", got), 32'(o_flags), 32'(bflg[got]));
            got++;
         end
         if (i_in_valid && o_in_ready) acc++;
         @(negedge clk);
      end
      i_in_valid = 1'b0;
      chk("bp_delivered", got, 32'd5);
      stale = 0;
      for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (o_out_valid) stale++; end
      chk("bp_no_duplicate", stale, 32'd0);

      // flush with 3 in flight
      @(negedge clk);
      i_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_in_valid = 1'b1; i_x = 32'h3FC00000; i_y = 32'h40000000; i_tag = 5'(k + 1);
         @(negedge clk);
      end
      chk("flush_prefill_valid", 32'(o_out_valid), 32'd1);
      i_flush = 1'b1; #1;
      chk("flush_in_ready", 32'(o_in_ready), 32'd0);
      @(negedge clk);
      i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1; #1;
      chk("flush_out_valid", 32'(o_out_valid), 32'd0);
      stale = 0;
      for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (o_out_valid) stale++; end
      chk("flush_no_stale", stale, 32'd0);
      run_one(32'h3FC00000, 32'h40000000, 3'd0, 5'd9, res, flg, otag, lat);
      chk("post_flush_result", res, 32'h40400000);
      chk("post_flush_tag", 32'(otag), 32'd9);

      // reset mid-stream
      @(negedge clk);
      i_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_in_valid = 1'b1; i_x = 32'h3FC00000; i_y = 32'h40000000; i_tag = 5'(k + 11);
         @(negedge clk);
      end
      i_in_valid = 1'b0;
      i_rst_n = 1'b0; #1;
      chk("midrst_out_valid", 32'(o_out_valid), 32'd0);
      chk("midrst_result", o_result, 32'h0);
      chk("midrst_flags", 32'(o_flags), 32'h0);
      chk("midrst_out_tag", 32'(o_out_tag), 32'h0);
      @(negedge clk);
      i_rst_n = 1'b1; i_out_ready = 1'b1; #1;
      chk("midrst_in_ready", 32'(o_in_ready), 32'd1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (o_out_valid) stale++; end
      chk("midrst_no_stale", stale, 32'd0);

      // randomized traffic with random backpressure
      sent = 0;
      @(negedge clk);
      for (int c = 0; c < 4000 && (sent < 300 || sb.size() > 0); c++) begin
         i_out_ready = ($urandom_range(0, 9) < 7);
         if (sent < 300 && $urandom_range(0, 3) != 0) begin
            i_in_valid = 1'b1; i_x = rand_op(); i_y = rand_op();
            i_rm = 3'($urandom_range(0, 7)); i_tag = 5'(sent);
         end else begin
            i_in_valid = 1'b0;
         end
         #1;
         if (o_out_valid && i_out_ready) begin
            if (sb.size() == 0) begin
               chk("rand_unexpected_output", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rand_result", o_result, e.res);
               chk("rand_flags", 32'(o_flags), 32'(e.flg));
               chk("rand_tag", 32'(o_out_tag), 32'(e.tag));
            end
         end
         if (i_in_valid && o_in_ready) begin
            model(i_x, i_y, i_rm, e.res, e.flg);
            e.tag = i_tag;
            sb.push_back(e);
            sent++;
         end
         @(negedge clk);
      end
      i_in_valid = 1'b0;
      chk("rand_all_sent", sent, 32'd300);
      chk("rand_all_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fpu_fmul_pipe.md
# fpu_fmul_pipe

Parametrised, elastic floating-point multiply pipeline for the FPU: computes `x*y` for any IEEE-754 binary format selected by `EXP_W`/`MAN_W`, with all five rounding modes and per-stage valid/ready backpressure. A `flush` input kills all in-flight operations, and an opaque `tag` travels with each operation. It sits beside the FMA pipeline and serves FMUL traffic, so FMUL no longer occupies the longer FMA pipe. Subnormals are handled as DAZ/FTZ.

## Interface
- `EXP_W`, default 8: exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored mantissa width; hidden bit is implicit.
- `TAG_W`, default 5: width of the pass-through tag.
- `STAGES`, default 3: register stages including the output register; minimum 2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  stage 1 can accept this cycle.
- `x`, `y`  in  EXP_W+MAN_W+1  operands.
- `rm`  in  3  rounding mode.
- `tag`  in  TAG_W  returned unchanged with the result.
- `flush`  in  1  synchronous kill of all in-flight operations.
- `out_valid`  out  1  result, flags and `out_tag` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  EXP_W+MAN_W+1  packed product.
- `flags`  out  5  {NV, DZ, OF, UF, NX}.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- **Stage 1 capture (combinational path into stage 1).**
  - Classify both operands.
  - Multiply the (MAN_W+1)x(MAN_W+1) significands.
  - Form exponent = ex + ey - bias at EXP_W+2 bits, signed.
  - Sign = xs ^ ys.
- **Subnormal inputs (exp=0, man≠0):** treated as signed zero. No flag.
- **Special cases, highest priority first:**
  - Any NaN input, or inf×0: canonical qNaN (sign 0, exp all ones, mantissa MSB 1, rest 0).
  - NV is set for any sNaN input or for inf×0.
  - Otherwise inf×finite-nonzero or inf×inf: signed inf, flags 0.
  - Otherwise any zero: signed zero, flags 0.
- **Stage 1 → stage 2: normalise, round, pack.**
  - If product bit 2·MAN_W+1 is set: shift right by 1 and add 1 to the exponent.
  - Guard = first dropped bit; sticky = OR of the rest.
- **Rounding modes:**
  - 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
  - 101–111 behave as RNE and raise no flag.
  - If rounding carries out of the mantissa, the exponent increments.
- **Overflow (rounded biased exponent ≥ 2^EXP_W-1):** OF|NX.
  - RNE and RMM: inf.
  - RTZ: max finite.
  - RDN: -inf if negative, else +max finite.
  - RUP: +inf if positive, else -max finite.
- **Underflow (rounded biased exponent ≤ 0, FTZ):** signed zero, UF|NX.
- **Inexact:** NX whenever guard|sticky is set. DZ is always 0.
- **Stages 3..STAGES:** holding registers only. Each stage has its own valid bit and carries result, flags and tag.
- **Handshake:**
  - ready_STAGES = !v_STAGES | out_ready.
  - ready_i = !v_i | ready_(i+1).
  - in_ready = ready_1 & !flush.
  - Bubbles collapse, so capacity is STAGES operations.
- **Flush:** on the edge where `flush`=1, every valid bit clears and `in_valid` is ignored. A result presented with `out_ready`=1 in that same cycle is still counted as delivered.

## Timing
- **Reset:** every valid bit is 0; `out_valid`=0, `result`=0, `flags`=0, `out_tag`=0. `in_ready`=1 after reset deasserts.
- **Latency:** an operation accepted on edge N shows `out_valid`=1 after edge N+STAGES-1, provided no stall.
- **Throughput:** 1 operation per cycle while `out_ready`=1.
- **Output stability:** `out_valid`, `result`, `flags` and `out_tag` hold steady while `out_valid`=1 and `out_ready`=0.
- **Simultaneous events:** a stage may load and unload on the same edge when full and downstream is ready.
- **Reset mid-operation:** in-flight operations are lost and no `out_valid` pulse occurs.
- `in_ready` has a combinational path from `out_ready` and `flush`.

## Test plan
- **Basic product (STAGES=3, RNE):** x=0x3FC00000, y=0x40000000, tag=5 → result 0x40400000, flags 0, out_tag 5, `out_valid` 2 cycles after accept.
- **Rounding:** x=y=0x3F800001:
  - RNE → 0x3F800002, flags 00001.
  - RUP → 0x3F800003, flags 00001.
  - RTZ → 0x3F800002, flags 00001.
- **Specials:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flags 10000.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, flags 10000.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
- **Overflow and underflow:**
  - 0x7F7FFFFF × 0x40000000, RNE → 0x7F800000, flags 00101.
  - Same operands, RTZ → 0x7F7FFFFF, flags 00101.
  - 0x00800000 × 0x3F000000 → 0x00000000, flags 00011.
- **Backpressure:** hold `out_ready`=0 and offer 5 back-to-back operations.
  - Exactly 3 are accepted, then `in_ready`=0.
  - Release `out_ready`: all 5 results emerge in order, tags intact, none lost or duplicated.
- **Flush and reset:**
  - With 3 operations in flight, pulse `flush` → `out_valid`=0 on the next cycle and no stale result afterwards.
  - Repeat with `rst_n` asserted mid-stream → all outputs return to 0.
